muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared Mult and Div units and the HI/LO register pair for the multicycle MIPS core.
//  Accepts one-cycle start requests from the control unit, pulses the selected unit's start input and waits for its done flag.
//  It then drives the Div/Mult select mux and loads HI and LO together.
//  Also detects a zero divisor, flags it as an exception, and enforces a watchdog on unit completion.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT-state cycles before Timeout; legal range 2..(2**CNT_W)
//  CNT_W           6   watchdog counter width; must satisfy 2**CNT_W >= TIMEOUT_CYCLES
// PORTS
//  Clk         in   1   single clock, rising edge
//  Reset       in   1   synchronous, active-low reset
//  StartMult   in   1   1-cycle request: run mult (operands already in A/B)
//  StartDiv    in   1   1-cycle request: run div
//  Abort       in   1   cancel the current operation (e.g. from the exception path)
//  Divisor     in   32  divisor operand (B register output)
//  MultDone    in   1   Mult unit result valid (1-cycle pulse)
//  DivDone     in   1   Div unit result valid (1-cycle pulse)
//  MultGo      out  1   1-cycle start pulse to Mult
//  DivGo       out  1   1-cycle start pulse to Div
//  DivMultSel  out  1   HI/LO source mux: 0=Div, 1=Mult
//  HighLoad    out  1   load enable for HI
//  LowLoad     out  1   load enable for LO
//  Busy        out  1   high in every non-IDLE state
//  Done        out  1   1-cycle: HI/LO updated, op complete
//  DivZero     out  1   1-cycle: div requested with Divisor==0
//  Timeout     out  1   1-cycle: unit failed to finish in time
// BEHAVIOUR
//  All outputs are registered and Moore-decoded from state.
//  DivMultSel is a held register: it changes only on an accepted start.
//  Reset (Reset==0 at posedge): state=IDLE, counter=0, all outputs 0, DivMultSel=0. Reset overrides everything, mid-op included.
//  States and transitions:
//   IDLE   StartMult -> M_GO, DivMultSel<=1.
//          else StartDiv & Divisor==0 -> D_EXC.
//          else StartDiv -> D_GO, DivMultSel<=0.
//          StartMult wins when both starts are high.
//   M_GO   MultGo=1 -> M_WAIT, cnt<=0.
//   D_GO   DivGo=1  -> D_WAIT, cnt<=0.
//   M_WAIT / D_WAIT
//          own done seen -> WB.
//          else cnt==TIMEOUT_CYCLES-1 -> TOUT.
//          else cnt++.
//          Done wins over timeout in the same cycle.
//          The other unit's done is ignored.
//   WB     HighLoad=LowLoad=1 -> FIN.
//   FIN    Done=1 -> IDLE.
//   D_EXC  DivZero=1; HI/LO untouched -> IDLE.
//   TOUT   Timeout=1; HI/LO untouched -> IDLE.
//  Abort: in any non-IDLE state the next state is IDLE, with no load, Done, DivZero or Timeout.
//   Abort beats done and timeout in the same cycle. Abort in IDLE is ignored and suppresses acceptance of a start that cycle.
//  Start requests while Busy are dropped, not queued.
//  Latency from start edge t:
//   MultGo/DivGo at t+1.
//   Unit done at cycle k -> loads at k+1, Done at k+2.
//   Zero divide -> DivZero at t+1, Busy at t+1, IDLE at t+2.
//  HighLoad and LowLoad are always asserted together.
// TESTING
//  StartMult@t0, MultDone@t5 -> MultGo@t1; HighLoad=LowLoad=1,Sel=1 @t6; Done@t7; Busy t1..t7.
//  StartDiv, Divisor=7, DivDone 33 cycles after DivGo -> Sel=0, loads then Done; no Timeout.
//  StartDiv, Divisor=0 -> DivZero@t1 only; DivGo, HighLoad, Done never asserted; IDLE@t2.
//  StartMult, no MultDone -> Timeout after 40 M_WAIT cycles; no loads; a new StartDiv is accepted next.
//  Abort coincident with DivDone in D_WAIT -> IDLE, no loads/Done.
//  StartMult+StartDiv same cycle -> mult only.
//  Reset=0 mid M_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Bundles the control-unit requests, unit handshakes and HI/LO control
//   outputs of the mult/div sequencer.
//   master : control unit / unit side (drives requests, done flags, divisor)
//   slave  : the sequencer itself (drives go pulses, loads, status)
interface muldiv_sequencer_if;
  localparam int unsigned DataW = 32;

  logic             StartMult;
  logic             StartDiv;
  logic             Abort;
  logic [DataW-1:0] Divisor;
  logic             MultDone;
  logic             DivDone;
  logic             MultGo;
  logic             DivGo;
  logic             DivMultSel;
  logic             HighLoad;
  logic             LowLoad;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic             Timeout;

  modport master (
    output StartMult, StartDiv, Abort, Divisor, MultDone, DivDone,
    input  MultGo, DivGo, DivMultSel, HighLoad, LowLoad, Busy, Done,
           DivZero, Timeout
  );

  modport slave (
    input  StartMult, StartDiv, Abort, Divisor, MultDone, DivDone,
    output MultGo, DivGo, DivMultSel, HighLoad, LowLoad, Busy, Done,
           DivZero, Timeout
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences the shared Mult/Div units and the HI/LO register pair of the
//   multicycle MIPS core: pulses the selected unit's start, waits for its done
//   flag under a watchdog, then loads HI and LO together and reports Done.
//   A divide with a zero divisor is flagged as DivZero without running Div.
// Ports
//   Clk   : rising-edge clock
//   Reset : synchronous active-low reset
//   bus   : muldiv_sequencer_if.slave (requests in; go pulses, HI/LO
//           control and status out). All outputs are registered.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input logic                Clk,
  input logic                Reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    M_GO   = 4'd1,
    D_GO   = 4'd2,
    M_WAIT = 4'd3,
    D_WAIT = 4'd4,
    WB     = 4'd5,
    FIN    = 4'd6,
    D_EXC  = 4'd7,
    TOUT   = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic multGo, divGo, divMultSel, highLoad, lowLoad;
  logic busy, done, divZero, timeout;

  logic divisorZero;
  assign divisorZero = (bus.Divisor == 32'd0);

  // State and registered outputs are updated together, so each output is high
  // exactly while the FSM sits in the state that owns it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      multGo     <= 1'b0;
      divGo      <= 1'b0;
      divMultSel <= 1'b0;
      highLoad   <= 1'b0;
      lowLoad    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divZero    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      multGo   <= 1'b0;
      divGo    <= 1'b0;
      highLoad <= 1'b0;
      lowLoad  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      divZero  <= 1'b0;
      timeout  <= 1'b0;

      // Abort cancels any in-flight op ahead of done/timeout.
      if (state != IDLE && bus.Abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Abort in IDLE blocks acceptance; mult has priority over div.
            if (!bus.Abort) begin
              if (bus.StartMult) begin
                state      <= M_GO;
                multGo     <= 1'b1;
                busy       <= 1'b1;
                divMultSel <= 1'b1;
              end else if (bus.StartDiv && divisorZero) begin
                state   <= D_EXC;
                divZero <= 1'b1;
                busy    <= 1'b1;
              end else if (bus.StartDiv) begin
                state      <= D_GO;
                divGo      <= 1'b1;
                busy       <= 1'b1;
                divMultSel <= 1'b0;
              end
            end
          end

          M_GO: begin
            state <= M_WAIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end

          D_GO: begin
            state <= D_WAIT;
            cnt   <= '0;
            busy  <= 1'b1;
          end

          M_WAIT, D_WAIT: begin
            busy <= 1'b1;
            // Only the selected unit's done counts; done beats the watchdog.
            if ((state == M_WAIT) ? bus.MultDone : bus.DivDone) begin
              state    <= WB;
              highLoad <= 1'b1;
              lowLoad  <= 1'b1;
            end else if (cnt == CntLast) begin
              state   <= TOUT;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          WB: begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b1;
          end

          FIN, D_EXC, TOUT: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.MultGo     = multGo;
  assign bus.DivGo      = divGo;
  assign bus.DivMultSel = divMultSel;
  assign bus.HighLoad   = highLoad;
  assign bus.LowLoad    = lowLoad;
  assign bus.Busy       = busy;
  assign bus.Done       = done;
  assign bus.DivZero    = divZero;
  assign bus.Timeout    = timeout;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed stimulus for the mult/div sequencer. Stimulus pushes the expected
//   output vector of every pulse cycle into a scoreboard queue; a negedge
//   monitor pops and compares whenever any pulse output is high.
//   Output vector: {MultGo, DivGo, DivMultSel, HighLoad, LowLoad, Busy,
//                   Done, DivZero, Timeout}
module tb_muldiv_sequencer;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  v;
  } exp_t;

  logic        Clk;
  logic        Reset;
  int unsigned cyc;
  int unsigned nChecks;
  int unsigned nFail;
  exp_t        sbq[$];

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(40),
    .CNT_W(6)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  logic [8:0] outVec;
  assign outVec = {bus.MultGo, bus.DivGo, bus.DivMultSel, bus.HighLoad,
                   bus.LowLoad, bus.Busy, bus.Done, bus.DivZero, bus.Timeout};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [8:0] vec(input logic mg, input logic dg,
                                     input logic sel, input logic ld,
                                     input logic bsy, input logic dn,
                                     input logic dz, input logic to);
    return {mg, dg, sel, ld, ld, bsy, dn, dz, to};
  endfunction

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic goTo(input int unsigned c);
    while (cyc < c) tick();
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      nChecks++;
      nFail++;
      $display("FAIL missing_event: expected %b at cyc %0d, not seen", e.v, e.cyc);
    end
    if (bus.MultGo || bus.DivGo || bus.HighLoad || bus.LowLoad || bus.Done ||
        bus.DivZero || bus.Timeout) begin
      nChecks++;
      if (sbq.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_event @cyc %0d: got %b, none required", cyc, outVec);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.v !== outVec) begin
          nFail++;
          $display("FAIL event @cyc %0d: got %b, required %b at cyc %0d",
                   cyc, outVec, e.v, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    int unsigned u;
    nChecks = 0;
    nFail   = 0;
    Reset = 1'b0;
    bus.StartMult = 1'b0;
    bus.StartDiv  = 1'b0;
    bus.Abort     = 1'b0;
    bus.Divisor   = 32'd0;
    bus.MultDone  = 1'b0;
    bus.DivDone   = 1'b0;
    tick();
    tick();
    check("reset_outputs", outVec, 9'd0);
    Reset = 1'b1;
    tick();
    check("idle_after_reset", outVec, 9'd0);

    // Mult: done at t+5 -> loads t+6, Done t+7; a stray DivDone is ignored
    t = cyc;
    bus.StartMult = 1'b1;
    push(t + 1, vec(1, 0, 1, 0, 1, 0, 0, 0));
    push(t + 6, vec(0, 0, 1, 1, 1, 0, 0, 0));
    push(t + 7, vec(0, 0, 1, 0, 1, 1, 0, 0));
    tick();
    bus.StartMult = 1'b0;
    goTo(t + 3);
    bus.DivDone = 1'b1;
    tick();
    bus.DivDone = 1'b0;
    check("mult_wait_busy", outVec, vec(0, 0, 1, 0, 1, 0, 0, 0));
    goTo(t + 5);
    bus.MultDone = 1'b1;
    tick();
    bus.MultDone = 1'b0;
    goTo(t + 8);
    check("mult_back_idle", outVec, vec(0, 0, 1, 0, 0, 0, 0, 0));

    // Zero divisor: DivZero at t+1 only, Sel untouched, IDLE at t+2
    t = cyc;
    bus.StartDiv = 1'b1;
    bus.Divisor  = 32'd0;
    push(t + 1, vec(0, 0, 1, 0, 1, 0, 1, 0));
    tick();
    bus.StartDiv = 1'b0;
    bus.Divisor  = 32'd7;
    tick();
    check("divzero_idle", outVec, vec(0, 0, 1, 0, 0, 0, 0, 0));

    // Div by 7: DivDone 33 cycles after DivGo, no timeout
    t = cyc;
    bus.StartDiv = 1'b1;
    bus.Divisor  = 32'd7;
    push(t + 1,  vec(0, 1, 0, 0, 1, 0, 0, 0));
    push(t + 35, vec(0, 0, 0, 1, 1, 0, 0, 0));
    push(t + 36, vec(0, 0, 0, 0, 1, 1, 0, 0));
    tick();
    bus.StartDiv = 1'b0;
    goTo(t + 34);
    bus.DivDone = 1'b1;
    tick();
    bus.DivDone = 1'b0;
    goTo(t + 37);
    check("div_back_idle", outVec, vec(0, 0, 0, 0, 0, 0, 0, 0));

    // Mult with no done: Timeout after 40 wait cycles; StartDiv while busy dropped
    t = cyc;
    bus.StartMult = 1'b1;
    push(t + 1,  vec(1, 0, 1, 0, 1, 0, 0, 0));
    push(t + 42, vec(0, 0, 1, 0, 1, 0, 0, 1));
    tick();
    bus.StartMult = 1'b0;
    goTo(t + 10);
    bus.StartDiv = 1'b1;
    bus.Divisor  = 32'd5;
    tick();
    bus.StartDiv = 1'b0;
    goTo(t + 41);
    check("last_wait_cycle", outVec, vec(0, 0, 1, 0, 1, 0, 0, 0));
    goTo(t + 43);
    check("timeout_idle", outVec, vec(0, 0, 1, 0, 0, 0, 0, 0));

    // New div accepted after timeout; Abort coincident with DivDone
    u = cyc;
    bus.StartDiv = 1'b1;
    bus.Divisor  = 32'd5;
    push(u + 1, vec(0, 1, 0, 0, 1, 0, 0, 0));
    tick();
    bus.StartDiv = 1'b0;
    goTo(u + 5);
    bus.DivDone = 1'b1;
    bus.Abort   = 1'b1;
    tick();
    bus.DivDone = 1'b0;
    bus.Abort   = 1'b0;
    check("abort_idle", outVec, vec(0, 0, 0, 0, 0, 0, 0, 0));
    goTo(u + 10);

    // Both starts together: mult only
    t = cyc;
    bus.StartMult = 1'b1;
    bus.StartDiv  = 1'b1;
    bus.Divisor   = 32'd3;
    push(t + 1, vec(1, 0, 1, 0, 1, 0, 0, 0));
    push(t + 4, vec(0, 0, 1, 1, 1, 0, 0, 0));
    push(t + 5, vec(0, 0, 1, 0, 1, 1, 0, 0));
    tick();
    bus.StartMult = 1'b0;
    bus.StartDiv  = 1'b0;
    goTo(t + 3);
    bus.MultDone = 1'b1;
    tick();
    bus.MultDone = 1'b0;
    goTo(t + 6);
    check("both_back_idle", outVec, vec(0, 0, 1, 0, 0, 0, 0, 0));

    // Abort in IDLE suppresses a start; Sel stays at mult
    t = cyc;
    bus.StartDiv = 1'b1;
    bus.Divisor  = 32'd9;
    bus.Abort    = 1'b1;
    tick();
    bus.StartDiv = 1'b0;
    bus.Abort    = 1'b0;
    check("idle_abort_drop", outVec, vec(0, 0, 1, 0, 0, 0, 0, 0));
    tick();

    // Reset mid M_WAIT: everything, including Sel, cleared next cycle
    t = cyc;
    bus.StartMult = 1'b1;
    push(t + 1, vec(1, 0, 1, 0, 1, 0, 0, 0));
    tick();
    bus.StartMult = 1'b0;
    goTo(t + 4);
    Reset = 1'b0;
    tick();
    check("reset_mid_op", outVec, 9'd0);
    Reset = 1'b1;
    tick();
    bus.MultDone = 1'b1;
    tick();
    bus.MultDone = 1'b0;
    tick();
    tick();
    check("post_reset_idle", outVec, 9'd0);

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      nChecks++;
      nFail++;
      $display("FAIL leftover_event: expected %b at cyc %0d, not seen", e.v, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
